// File: rtl/cam_capture_ctrl_if.sv
// rtl/cam_capture_ctrl_if.sv - frame-buffer write bus between capture controller and RAM
//
// Purpose: carries one registered 16-bit pixel write per strobe.
// Signals:
//   wr_en    buffer write strobe
//   wr_addr  linear pixel address (line*IMG_W + pixel)
//   wr_data  RGB565 pixel, {high byte, low byte}
// Modports: master drives the bus (capture controller), slave receives it (RAM side).

interface cam_capture_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - single-frame DVP camera capture sequencer with RGB565 packing
//
// Purpose: arms on start, waits for a full vsync pulse, packs byte pairs from the
// camera into 16-bit pixels and writes them to a linear frame buffer. Malformed
// frames (short line, odd byte count, early vsync) are flagged with done.
// Optional build macro: CAM_DECIMATE_EN enables 2:1 decimation in both axes.
// Ports:
//   clk        in   pixel clock (camera xclk domain)
//   reset      in   synchronous, active-high
//   start      in   1-cycle pulse, arm capture of next frame
//   cam_vsync  in   frame sync, active high
//   cam_href   in   line valid, active high
//   cam_dat    in   8-bit pixel byte, high byte first
//   busy       out  high from accepted start until done
//   done       out  1-cycle pulse at frame end
//   frame_err  out  error flag, valid with done, held until next accepted start
//   wr         master port of cam_capture_ctrl_if (wr_en/wr_addr/wr_data)

module cam_capture_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [7:0]           cam_dat,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err,
  cam_capture_ctrl_if.master   wr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WFALL = 3'd2;
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

`ifdef CAM_DECIMATE_EN
  localparam int SPAN  = 2 * IMG_W;
  localparam int LSPAN = 2 * IMG_H;
`else
  localparam int SPAN  = IMG_W;
  localparam int LSPAN = IMG_H;
`endif

  // pcnt counts sensor pixels of the current line and saturates at SPAN, so
  // "line long enough" is simply pcnt reaching SPAN.
  localparam int PW = $clog2(SPAN + 1);
  localparam int LW = $clog2(LSPAN + 1);

  localparam logic [PW-1:0]     SPAN_C    = PW'(SPAN);
  localparam logic [LW-1:0]     LAST_LINE = LW'(LSPAN - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);

  logic [2:0]        state;
  logic              phase_lo;
  logic [7:0]        hi_byte;
  logic [PW-1:0]     pcnt;
  logic [LW-1:0]     lcnt;
  logic [ADDR_W-1:0] line_base;
  logic              href_q;
  logic              err_sticky;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;

  logic              pix_keep;
  logic              line_keep;
  logic [ADDR_W-1:0] pix_off;
  logic              line_short;

`ifdef CAM_DECIMATE_EN
  // Even sensor pixels/lines are stored; odd ones are consumed only.
  assign pix_keep  = ~pcnt[0] & (pcnt < SPAN_C);
  assign pix_off   = ADDR_W'(pcnt >> 1);
  assign line_keep = ~lcnt[0];
`else
  assign pix_keep  = (pcnt < SPAN_C);
  assign pix_off   = ADDR_W'(pcnt);
  assign line_keep = 1'b1;
`endif

  // A dangling high byte (phase_lo still set) means an odd byte count.
  assign line_short = (pcnt < SPAN_C) | phase_lo;

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      phase_lo   <= 1'b0;
      hi_byte    <= '0;
      pcnt       <= '0;
      lcnt       <= '0;
      line_base  <= '0;
      href_q     <= 1'b0;
      err_sticky <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      done    <= 1'b0;
      wr_en_q <= 1'b0;
      href_q  <= cam_href;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ARM;
            busy       <= 1'b1;
            frame_err  <= 1'b0;
            err_sticky <= 1'b0;
          end
        end

        // Arming only looks for vsync high, so a frame already running is skipped.
        S_ARM: begin
          if (cam_vsync) state <= S_WFALL;
        end

        S_WFALL: begin
          if (!cam_vsync) begin
            state     <= S_CAP;
            lcnt      <= '0;
            pcnt      <= '0;
            phase_lo  <= 1'b0;
            line_base <= '0;
          end
        end

        S_CAP: begin
          if (cam_vsync) begin
            // Early vsync aborts the frame; it also takes priority over href.
            err_sticky <= 1'b1;
            frame_err  <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_DONE;
          end else if (cam_href) begin
            if (!phase_lo) begin
              hi_byte  <= cam_dat;
              phase_lo <= 1'b1;
            end else begin
              phase_lo <= 1'b0;
              if (pcnt < SPAN_C) pcnt <= pcnt + PW'(1);
              if (line_keep && pix_keep) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= line_base + pix_off;
                wr_data_q <= {hi_byte, cam_dat};
              end
            end
          end else if (href_q) begin
            // End of line on the falling edge of href.
            if (line_short) err_sticky <= 1'b1;
            phase_lo <= 1'b0;
            pcnt     <= '0;
            lcnt     <= lcnt + LW'(1);
            if (line_keep) line_base <= line_base + IMG_W_A;
            if (lcnt == LAST_LINE) begin
              frame_err <= err_sticky | line_short;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - randomized self-checking bench for cam_capture_ctrl

module tb_cam_capture_ctrl;

  localparam int IMG_W  = 64;
  localparam int IMG_H  = 32;
  localparam int ADDR_W = 11;
`ifdef CAM_DECIMATE_EN
  localparam int DEC = 2;
`else
  localparam int DEC = 1;
`endif
  localparam int SPAN = IMG_W * DEC;
  localparam int NL   = IMG_H * DEC;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_dat;
  logic       busy;
  logic       done;
  logic       frame_err;

  cam_capture_ctrl_if #(.ADDR_W(ADDR_W)) wr_if ();

  cam_capture_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_dat   (cam_dat),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .wr        (wr_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          pushed = 0;
  int          done_cnt = 0;
  logic        done_err = 1'b0;
  logic [15:0] first_data = '0;
  bit          model_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every write must match the next one the model predicted.
  always @(negedge clk) begin
    if (wr_if.wr_en === 1'b1) begin
      if (wr_cnt == 0) first_data = wr_if.wr_data;
      wr_cnt++;
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_if.wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_if.wr_data), 32'(e.d));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_err = frame_err;
    end
  end

  // Drives one sensor line. L<0 means the controller must not be capturing.
  task automatic send_line(input int L, input int nbytes, input bit pat);
    logic [7:0] hi;
    logic [7:0] b;
    int         s;
    hi = '0;
    if (L >= 0 && (nbytes < 2 * SPAN || (nbytes % 2) != 0)) model_err = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      b = pat ? k[7:0] : 8'($urandom);
      if ((k % 2) == 0) begin
        hi = b;
      end else if (L >= 0) begin
        s = k / 2;
        if ((L % DEC) == 0 && (s % DEC) == 0 && (s / DEC) < IMG_W) begin
          exp_q.push_back('{a: ADDR_W'((L / DEC) * IMG_W + s / DEC), d: {hi, b}});
          pushed++;
        end
      end
      cam_href = 1'b1;
      cam_dat  = b;
      tick();
    end
    cam_href = 1'b0;
    cam_dat  = 8'($urandom);
    repeat (2 + $urandom_range(0, 2)) tick();
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    repeat (4) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int abort_at, input int odd_line, input int odd_bytes,
                           input bit pat, input bit rnd);
    int len;
    int base;
    int i;
    model_err = 1'b0;
    wr_cnt    = 0;
    pushed    = 0;
    base      = done_cnt;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    repeat (3) tick();
    vsync_pulse();
    for (int L = 0; L < NL; L++) begin
      if (L == abort_at) begin
        model_err = 1'b1;
        cam_vsync = 1'b1;
        tick();
        check("abort_done_latency", 32'(done), 32'd1);
        cam_vsync = 1'b0;
        break;
      end
      if (L == 3) pulse_start();
      len = 2 * SPAN;
      if (L == odd_line) begin
        len = odd_bytes;
      end else if (rnd) begin
        case ($urandom_range(0, 9))
          0:       len = 2 * SPAN - 2 * $urandom_range(1, 5);
          1:       len = 2 * SPAN + 1;
          2:       len = 2 * SPAN + 2 * $urandom_range(1, 3);
          3:       len = 2 * SPAN - 1;
          default: len = 2 * SPAN;
        endcase
      end
      send_line(L, len, pat);
    end
    i = 0;
    while (done_cnt == base && i < 60) begin
      tick();
      i++;
    end
    check("done_count", 32'(done_cnt - base), 32'd1);
    check("frame_err", 32'(done_err), 32'(model_err));
    check("write_count", 32'(wr_cnt), 32'(pushed));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  initial begin
    int base;
    reset     = 1'b1;
    start     = 1'b0;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_dat   = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_wr_en", 32'(wr_if.wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_if.wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_if.wr_data), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Clean frame with byte = index pattern.
    run_frame(-1, -1, 0, 1'b1, 1'b0);
    check("t1_writes", 32'(wr_cnt), 32'(IMG_W * IMG_H));
    check("t1_first_data", 32'(first_data), 32'h0001);
    check("t1_err", 32'(done_err), 32'd0);

    // Short line (60 stored pixels) on stored line 5.
    run_frame(-1, 5 * DEC, 2 * 60 * DEC, 1'b0, 1'b0);
    check("t2_err", 32'(done_err), 32'd1);

    // Line with one extra odd byte beyond a full line.
    run_frame(-1, 7 * DEC, 2 * SPAN + 1, 1'b0, 1'b0);
    check("t3_err", 32'(done_err), 32'd1);

    // Early vsync after 10 stored lines.
    run_frame(10 * DEC, -1, 0, 1'b0, 1'b0);
    check("t4_writes", 32'(wr_cnt), 32'(10 * IMG_W));

    // Randomized line lengths.
    run_frame(-1, -1, 0, 1'b0, 1'b1);

    // Mid-frame arming, then reset during capture.
    model_err = 1'b0;
    wr_cnt    = 0;
    pushed    = 0;
    base      = done_cnt;
    pulse_start();
    send_line(-1, 2 * SPAN, 1'b0);
    send_line(-1, 2 * SPAN, 1'b0);
    check("t5_no_write_before_vsync", 32'(wr_cnt), 32'd0);
    vsync_pulse();
    for (int L = 0; L < 3; L++) send_line(L, 2 * SPAN, 1'b0);
    send_line(3, 20, 1'b0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("t5_busy_after_reset", 32'(busy), 32'd0);
    repeat (10) tick();
    check("t5_no_done", 32'(done_cnt - base), 32'd0);
    check("t5_writes", 32'(wr_cnt), 32'(pushed));
    check("t5_queue", 32'(exp_q.size()), 32'd0);
    check("t5_frame_err", 32'(frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
